// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac: fractional baud generator emitting oversample, mid-bit and bit ticks.
// Period alternates between div_int and div_int+1 based on a fractional accumulator carry.
module uart_baud_gen_frac #(
    parameter int DIV_INT_W      = 16,
    parameter int DIV_FRAC_W     = 4,
    parameter int OVERSAMPLE     = 16,
    parameter int RESET_DIV_INT  = 3,
    parameter int RESET_DIV_FRAC = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DIV_INT_W-1:0]  div_int,
    input  logic [DIV_FRAC_W-1:0] div_frac,
    input  logic                  div_load,
    input  logic                  restart,
    output logic                  tick_os,
    output logic                  tick_mid,
    output logic                  tick_bit,
    output logic                  div_err
);
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int P_W  = DIV_INT_W + 1;

    logic [DIV_INT_W-1:0]  act_int_q, act_int_d, pend_int_q, pend_int_d;
    logic [DIV_FRAC_W-1:0] act_frac_q, act_frac_d, pend_frac_q, pend_frac_d;
    logic                  pend_vld_q, pend_vld_d, err_q, err_d;
    logic [DIV_FRAC_W-1:0] frac_acc_q, frac_acc_d;
    logic [P_W-1:0]        period_q, period_d, cyc_q, cyc_d;
    logic [OS_W-1:0]       os_q, os_d;
    logic                  tick_os_q, tick_os_d, tick_mid_q, tick_mid_d, tick_bit_q, tick_bit_d;

    logic [DIV_INT_W-1:0]  ld_int, eff_int, sel_int;
    logic [DIV_FRAC_W-1:0] eff_frac, sel_frac, acc_base;
    logic [DIV_FRAC_W:0]   sum;
    logic [P_W-1:0]        new_period;
    logic                  fire, reload;

    always_comb begin
        ld_int     = (div_int < DIV_INT_W'(2)) ? DIV_INT_W'(2) : div_int;
        eff_int    = pend_vld_q ? pend_int_q : act_int_q;
        eff_frac   = pend_vld_q ? pend_frac_q : act_frac_q;
        // a divisor loaded alongside restart takes effect for the very first period
        sel_int    = (restart && div_load) ? ld_int : eff_int;
        sel_frac   = (restart && div_load) ? div_frac : eff_frac;
        acc_base   = restart ? '0 : frac_acc_q;
        sum        = {1'b0, acc_base} + {1'b0, sel_frac};
        new_period = {1'b0, sel_int} + {{DIV_INT_W{1'b0}}, sum[DIV_FRAC_W]};
        fire       = enable && !restart && (cyc_q + P_W'(1) == period_q);
        reload     = restart || fire;
        tick_os_d  = fire;
        tick_mid_d = fire && (os_q == OS_W'(OVERSAMPLE / 2 - 1));
        tick_bit_d = fire && (os_q == OS_W'(OVERSAMPLE - 1));
        os_d       = restart ? '0 : fire ? os_q + OS_W'(1) : os_q;
        cyc_d      = reload ? '0 : enable ? cyc_q + P_W'(1) : cyc_q;
        period_d   = reload ? new_period : period_q;
        frac_acc_d = reload ? sum[DIV_FRAC_W-1:0] : frac_acc_q;
        // while stopped there is no period boundary to wait for, so pending applies at once
        act_int_d  = reload ? sel_int : !enable ? (div_load ? ld_int : eff_int) : act_int_q;
        act_frac_d = reload ? sel_frac : !enable ? (div_load ? div_frac : eff_frac) : act_frac_q;
        pend_int_d  = div_load ? ld_int : pend_int_q;
        pend_frac_d = div_load ? div_frac : pend_frac_q;
        pend_vld_d  = div_load ? (enable && !restart) : (reload || !enable) ? 1'b0 : pend_vld_q;
        err_d       = div_load ? (div_int < DIV_INT_W'(2)) : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_int_q   <= DIV_INT_W'(RESET_DIV_INT);
            act_frac_q  <= DIV_FRAC_W'(RESET_DIV_FRAC);
            pend_int_q  <= DIV_INT_W'(RESET_DIV_INT);
            pend_frac_q <= DIV_FRAC_W'(RESET_DIV_FRAC);
            pend_vld_q  <= 1'b0;
            err_q       <= 1'b0;
            frac_acc_q  <= DIV_FRAC_W'(RESET_DIV_FRAC);
            period_q    <= P_W'(RESET_DIV_INT);
            cyc_q       <= '0;
            os_q        <= '0;
            tick_os_q   <= 1'b0;
            tick_mid_q  <= 1'b0;
            tick_bit_q  <= 1'b0;
        end else begin
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            pend_vld_q  <= pend_vld_d;
            err_q       <= err_d;
            frac_acc_q  <= frac_acc_d;
            period_q    <= period_d;
            cyc_q       <= cyc_d;
            os_q        <= os_d;
            tick_os_q   <= tick_os_d;
            tick_mid_q  <= tick_mid_d;
            tick_bit_q  <= tick_bit_d;
        end
    end

    assign tick_os  = tick_os_q;
    assign tick_mid = tick_mid_q;
    assign tick_bit = tick_bit_q;
    assign div_err  = err_q;
endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// tb_uart_baud_gen_frac: scoreboarded tick-spacing checks for the fractional baud generator.
module tb_uart_baud_gen_frac;
    logic        clk = 1'b0, rst = 1'b1, enable = 1'b1, div_load = 1'b0, restart = 1'b0;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic        tick_os, tick_mid, tick_bit, div_err;

    uart_baud_gen_frac dut (
        .clk(clk), .rst(rst), .enable(enable), .div_int(div_int), .div_frac(div_frac),
        .div_load(div_load), .restart(restart), .tick_os(tick_os), .tick_mid(tick_mid),
        .tick_bit(tick_bit), .div_err(div_err)
    );

    always #5 clk = ~clk;

    typedef struct { int gap; bit mid; bit bt; } exp_t;
    typedef struct { int di; int df; bit same; int g0; int g1; int g2; int g3; bit err; } row_t;

    exp_t q[$];
    int   n_chk = 0, n_pass = 0, cyc = 0, last = 0, os_exp = 0;
    bit   mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (tick_os) begin
                if (q.size() == 0) chk("unexpected_tick", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("tick_gap", cyc - last, e.gap);
                    chk("tick_mid", int'(tick_mid), int'(e.mid));
                    chk("tick_bit", int'(tick_bit), int'(e.bt));
                end
                last = cyc;
            end
            if ((tick_mid || tick_bit) && !tick_os) chk("stray_mid_bit", 1, 0);
        end
    end

    task automatic push_gap(input int g);
        exp_t e;
        e.gap = g;
        e.mid = (os_exp == 7);
        e.bt  = (os_exp == 15);
        os_exp = (os_exp + 1) % 16;
        q.push_back(e);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (q.size() != 0 && n < max) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic do_load(input int di, input int df);
        @(negedge clk);
        div_load = 1'b1; div_int = 16'(di); div_frac = 4'(df);
        @(posedge clk);
        #1 div_load = 1'b0;
    endtask

    task automatic do_restart(input bit ld, input int di, input int df);
        @(negedge clk);
        restart = 1'b1; div_load = ld; div_int = 16'(di); div_frac = 4'(df);
        @(posedge clk);
        #1 restart = 1'b0; div_load = 1'b0;
        last = cyc;
        os_exp = 0;
    endtask

    row_t rows[6];
    int   reset_gaps[8];

    initial begin
        rows[0] = '{4, 0, 1'b0, 4, 4, 4, 4, 1'b0};
        rows[1] = '{4, 8, 1'b0, 4, 5, 4, 5, 1'b0};
        rows[2] = '{1, 0, 1'b0, 2, 2, 2, 2, 1'b1};
        rows[3] = '{5, 0, 1'b0, 5, 5, 5, 5, 1'b0};
        rows[4] = '{2, 4, 1'b1, 2, 2, 2, 3, 1'b0};
        rows[5] = '{6, 12, 1'b1, 6, 7, 7, 7, 1'b0};
        reset_gaps = '{3, 3, 4, 3, 3, 4, 3, 4};

        repeat (3) @(negedge clk);
        chk("rst_tick_os", int'(tick_os), 0);
        chk("rst_tick_mid", int'(tick_mid), 0);
        chk("rst_tick_bit", int'(tick_bit), 0);
        chk("rst_div_err", int'(div_err), 0);
        rst = 1'b0;
        last = cyc;
        os_exp = 0;
        for (int r = 0; r < 4; r++) for (int k = 0; k < 8; k++) push_gap(reset_gaps[k]);
        mon_on = 1'b1;
        drain(4000);
        mon_on = 1'b0;

        for (int i = 0; i < 6; i++) begin
            if (rows[i].same) do_restart(1'b1, rows[i].di, rows[i].df);
            else begin
                do_load(rows[i].di, rows[i].df);
                do_restart(1'b0, 0, 0);
            end
            chk($sformatf("div_err_row%0d", i), int'(div_err), int'(rows[i].err));
            for (int k = 0; k < 4; k++) begin
                push_gap(rows[i].g0); push_gap(rows[i].g1);
                push_gap(rows[i].g2); push_gap(rows[i].g3);
            end
            mon_on = 1'b1;
            drain(4000);
            mon_on = 1'b0;
        end

        begin
            int r0, nb, n;
            do_restart(1'b1, 4, 8);
            r0 = cyc; nb = 0; n = 0;
            while (nb < 16 && n < 3000) begin
                @(negedge clk);
                n++;
                if (tick_bit) nb++;
            end
            chk("span_16_bits", cyc - r0, 1152);
        end

        do_load(4, 0);
        do_restart(1'b0, 0, 0);
        push_gap(4);
        mon_on = 1'b1;
        drain(100);
        push_gap(4); push_gap(10); push_gap(10);
        @(posedge clk);
        @(negedge clk);
        div_load = 1'b1; div_int = 16'd10; div_frac = 4'd0;
        @(posedge clk);
        #1 div_load = 1'b0;
        drain(200);
        mon_on = 1'b0;

        do_load(5, 0);
        do_restart(1'b0, 0, 0);
        push_gap(5);
        mon_on = 1'b1;
        drain(100);
        push_gap(12);
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        enable = 1'b1;
        drain(100);
        mon_on = 1'b0;
        do_restart(1'b1, 6, 0);
        push_gap(6); push_gap(6); push_gap(6);
        mon_on = 1'b1;
        drain(100);
        mon_on = 1'b0;

        do_load(1, 0);
        do_restart(1'b0, 0, 0);
        chk("err_before_rst", int'(div_err), 1);
        begin
            int n = 0;
            while (!tick_os && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("tick_before_rst", int'(tick_os), 1);
        end
        rst = 1'b1;
        #1;
        chk("async_rst_tick_os", int'(tick_os), 0);
        chk("async_rst_div_err", int'(div_err), 0);
        @(negedge clk);
        rst = 1'b0;
        last = cyc;
        os_exp = 0;
        for (int k = 0; k < 8; k++) push_gap(reset_gaps[k]);
        mon_on = 1'b1;
        drain(200);
        mon_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
